// File: rtl/cpu_clk_pkg.sv
// rtl/cpu_clk_pkg.sv - shared state encoding and widths for the CPU step controller
package cpu_clk_pkg;

    localparam int CYCLE_CNT_W = 32;

    typedef enum logic [1:0] {
        RST_HOLD_S = 2'd0,
        RUN_S      = 2'd1,
        HALT_S     = 2'd2,
        STEP_S     = 2'd3
    } state_t;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-flop sync, stability filter and rising-edge pulse for a raw button
module btn_debounce #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic          sync_1;
    logic          sync_2;
    logic          prev;
    logic          level;
    logic [CW-1:0] stable_cnt;

    // Synchronize, restart the stability count on any change, accept the level once stable
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1     <= 1'b0;
            sync_2     <= 1'b0;
            prev       <= 1'b0;
            level      <= 1'b0;
            stable_cnt <= '0;
            pulse      <= 1'b0;
        end else begin
            sync_1 <= btn;
            sync_2 <= sync_1;
            prev   <= sync_2;
            pulse  <= 1'b0;
            if (sync_2 != prev) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CW'(DEB_CYCLES - 1)) begin
                // Single-cycle pulse only on an accepted 0->1 transition
                if (sync_2 && !level) begin
                    pulse <= 1'b1;
                end
                level <= sync_2;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cpu_step_ctrl.sv
// rtl/cpu_step_ctrl.sv - run/halt/single-step CPU clock and reset sequencer; STEP_CTRL_CYCLE_CNT_EN builds cycle_cnt
module cpu_step_ctrl
    import cpu_clk_pkg::*;
#(
    parameter int DIV_LOG2   = 3,
    parameter int RST_HOLD   = 4,
    parameter int DEB_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   run_sw,
    input  logic                   step_btn,
    output logic                   clk_cpu,
    output logic                   rst_cpu,
    output logic                   halted,
    output logic [CYCLE_CNT_W-1:0] cycle_cnt
);

    localparam int EW = $clog2(RST_HOLD + 1);

    state_t              state;
    logic [DIV_LOG2-1:0] div_cnt;
    logic [EW-1:0]       edge_cnt;
    logic                run_s1;
    logic                run_s2;
    logic                step_req;
    logic                div_wrap;

    assign div_wrap = &div_cnt;

    btn_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_step_deb (
        .clk  (clk),
        .rst  (rst),
        .btn  (step_btn),
        .pulse(step_req)
    );

    // Main sequencer: divider, reset hold, run/halt/step decisions and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RST_HOLD_S;
            clk_cpu  <= 1'b0;
            rst_cpu  <= 1'b1;
            halted   <= 1'b0;
            div_cnt  <= '0;
            edge_cnt <= '0;
            run_s1   <= 1'b0;
            run_s2   <= 1'b0;
        end else begin
            run_s1 <= run_sw;
            run_s2 <= run_s1;
            case (state)
                RST_HOLD_S: begin
                    div_cnt <= div_cnt + 1'b1;
                    if (div_wrap) begin
                        clk_cpu <= !clk_cpu;
                        if (!clk_cpu) begin
                            // Saturating count of rising edges seen while in reset
                            if (edge_cnt != EW'(RST_HOLD)) begin
                                edge_cnt <= edge_cnt + 1'b1;
                            end
                        end else if (edge_cnt == EW'(RST_HOLD)) begin
                            // Release reset together with a clk_cpu falling edge
                            rst_cpu <= 1'b0;
                            div_cnt <= '0;
                            if (run_s2) begin
                                state <= RUN_S;
                            end else begin
                                state  <= HALT_S;
                                halted <= 1'b1;
                            end
                        end
                    end
                end
                RUN_S: begin
                    div_cnt <= div_cnt + 1'b1;
                    if (div_wrap) begin
                        clk_cpu <= !clk_cpu;
                        // Only stop on a falling toggle so the running period completes
                        if (clk_cpu && !run_s2) begin
                            state  <= HALT_S;
                            halted <= 1'b1;
                        end
                    end
                end
                HALT_S: begin
                    if (run_s2) begin
                        state   <= RUN_S;
                        halted  <= 1'b0;
                        div_cnt <= '0;
                    end else if (step_req) begin
                        // Step starts with the high phase immediately
                        state   <= STEP_S;
                        halted  <= 1'b0;
                        div_cnt <= '0;
                        clk_cpu <= 1'b1;
                    end
                end
                STEP_S: begin
                    div_cnt <= div_cnt + 1'b1;
                    if (div_wrap) begin
                        if (clk_cpu) begin
                            clk_cpu <= 1'b0;
                        end else begin
                            state  <= HALT_S;
                            halted <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= RST_HOLD_S;
                end
            endcase
        end
    end

`ifdef STEP_CTRL_CYCLE_CNT_EN
    logic rise_evt;

    // A counted edge is any clk_cpu 0->1 toggle once the CPU is out of reset
    always_comb begin
        rise_evt = 1'b0;
        if (!rst_cpu) begin
            case (state)
                RUN_S:   rise_evt = div_wrap && !clk_cpu;
                HALT_S:  rise_evt = !run_s2 && step_req;
                default: rise_evt = 1'b0;
            endcase
        end
    end

    // Free-running wrap-around count of CPU rising edges
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt <= '0;
        end else if (rise_evt) begin
            cycle_cnt <= cycle_cnt + 1'b1;
        end
    end
`else
    assign cycle_cnt = '0;
`endif

endmodule
